// File: rtl/arm_dp_sequencer_pkg.sv
// arm_dp_pkg: shared opcodes, condition codes, FSM state type and opcode class helpers
//  for the ARM data-processing sequencer and its condition checker.
package arm_dp_pkg;
   localparam logic [3:0] OP_AND = 4'h0;
   localparam logic [3:0] OP_EOR = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_RSB = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_ADC = 4'h5;
   localparam logic [3:0] OP_SBC = 4'h6;
   localparam logic [3:0] OP_RSC = 4'h7;
   localparam logic [3:0] OP_TST = 4'h8;
   localparam logic [3:0] OP_TEQ = 4'h9;
   localparam logic [3:0] OP_CMP = 4'hA;
   localparam logic [3:0] OP_CMN = 4'hB;
   localparam logic [3:0] OP_ORR = 4'hC;
   localparam logic [3:0] OP_MOV = 4'hD;
   localparam logic [3:0] OP_BIC = 4'hE;
   localparam logic [3:0] OP_MVN = 4'hF;
   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;
   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
   function automatic logic is_compare(input logic [3:0] op);
      return op[3:2] == 2'b10;
   endfunction
   function automatic logic is_arith(input logic [3:0] op);
      return (op >= OP_SUB && op <= OP_RSC) || op == OP_CMP || op == OP_CMN;
   endfunction
   function automatic logic uses_carry(input logic [3:0] op);
      return op == OP_ADC || op == OP_SBC || op == OP_RSC;
   endfunction
endpackage

// File: rtl/arm_dp_sequencer_if.sv
// arm_dp_sequencer_if: op request, ALU drive/return and register-file writeback bundle
//  req_*  : op handshake from decode/operand fetch
//  alu_*  : operands out to the combinational ALU and its result/flags back
//  wb_*   : register-file write port handshake
//  slave modport is the sequencer side, master modport is the surrounding environment.
interface arm_dp_sequencer_if #(parameter int DATA_W = 32);
   logic              req_valid;
   logic              req_ready;
   logic [3:0]        req_cond;
   logic [3:0]        req_opcode;
   logic              req_s;
   logic [3:0]        req_rd;
   logic [DATA_W-1:0] req_a;
   logic [DATA_W-1:0] req_b;
   logic              req_sh_carry;
   logic [3:0]        alu_opcode;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic              alu_carry;
   logic [DATA_W-1:0] alu_result;
   logic              alu_n;
   logic              alu_z;
   logic              alu_c;
   logic              alu_v;
   logic              wb_valid;
   logic              wb_ready;
   logic [3:0]        wb_rd;
   logic [DATA_W-1:0] wb_data;
   modport slave (
      input  req_valid, req_cond, req_opcode, req_s, req_rd, req_a, req_b, req_sh_carry,
      output req_ready,
      output alu_opcode, alu_a, alu_b, alu_carry,
      input  alu_result, alu_n, alu_z, alu_c, alu_v,
      output wb_valid, wb_rd, wb_data,
      input  wb_ready
   );
   modport master (
      output req_valid, req_cond, req_opcode, req_s, req_rd, req_a, req_b, req_sh_carry,
      input  req_ready,
      input  alu_opcode, alu_a, alu_b, alu_carry,
      output alu_result, alu_n, alu_z, alu_c, alu_v,
      input  wb_valid, wb_rd, wb_data,
      output wb_ready
   );
endinterface

// File: rtl/arm_dp_sequencer_cond.sv
// arm_cond_check: combinational ARM condition-code evaluation
//  cond : 4-bit condition field
//  nzcv : current {N,Z,C,V}
//  pass : condition satisfied (NV never passes)
module arm_cond_check
   import arm_dp_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       pass
);
   logic n, z, c, v;
   assign {n, z, c, v} = nzcv;
   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = !z;
         COND_CS: pass = c;
         COND_CC: pass = !c;
         COND_MI: pass = n;
         COND_PL: pass = !n;
         COND_VS: pass = v;
         COND_VC: pass = !v;
         COND_HI: pass = c && !z;
         COND_LS: pass = !c || z;
         COND_GE: pass = n == v;
         COND_LT: pass = n != v;
         COND_GT: pass = !z && (n == v);
         COND_LE: pass = z || (n != v);
         COND_AL: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end
endmodule

// File: rtl/arm_dp_sequencer.sv
// arm_dp_sequencer: issues ARM data-processing ops to an external ALU and owns NZCV
//  clk, reset    : clock, synchronous active-high reset
//  bus (slave)   : req_* op handshake, alu_* ALU drive/return, wb_* register-file write
//  flags_we/wdata: external {N,Z,C,V} write (MSR path)
//  flags         : current {N,Z,C,V}
//  retired_cnt   : ops whose condition passed
//  skipped_cnt   : ops whose condition failed
module arm_dp_sequencer
   import arm_dp_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic               clk,
   input  logic               reset,
   arm_dp_sequencer_if.slave  bus,
   input  logic               flags_we,
   input  logic [3:0]         flags_wdata,
   output logic [3:0]         flags,
   output logic [CNT_W-1:0]   retired_cnt,
   output logic [CNT_W-1:0]   skipped_cnt
);
   state_t            state, state_nx;
   logic [3:0]        cond_q, op_q, rd_q, wb_rd_q;
   logic              s_q, shc_q, pass, upd;
   logic [DATA_W-1:0] a_q, b_q, wb_data_q;
   arm_cond_check u_cond (.cond(cond_q), .nzcv(flags), .pass(pass));
   assign bus.req_ready  = state == IDLE;
   assign bus.wb_valid   = state == WB;
   assign bus.wb_rd      = wb_rd_q;
   assign bus.wb_data    = wb_data_q;
   assign bus.alu_opcode = op_q;
   assign bus.alu_a      = a_q;
   assign bus.alu_b      = b_q;
   assign bus.alu_carry  = uses_carry(op_q) ? flags[1] : shc_q;
   // compares always write flags; other ops only with S set
   assign upd = state == EXEC && pass && (s_q || is_compare(op_q));
   always_ff @(posedge clk)
      if (reset) state <= IDLE;
      else       state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = bus.req_valid ? EXEC : IDLE;
         EXEC:    state_nx = (!pass || is_compare(op_q)) ? IDLE : WB;
         WB:      state_nx = bus.wb_ready ? IDLE : WB;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         {cond_q, op_q, rd_q, s_q, shc_q, a_q, b_q} <= '0;
         wb_rd_q     <= '0;
         wb_data_q   <= '0;
         flags       <= '0;
         retired_cnt <= '0;
         skipped_cnt <= '0;
      end else begin
         if (state == IDLE && bus.req_valid) begin
            cond_q <= bus.req_cond;
            op_q   <= bus.req_opcode;
            s_q    <= bus.req_s;
            rd_q   <= bus.req_rd;
            a_q    <= bus.req_a;
            b_q    <= bus.req_b;
            shc_q  <= bus.req_sh_carry;
         end
         if (state == EXEC && pass) begin
            retired_cnt <= retired_cnt + 1'b1;
            wb_rd_q     <= rd_q;
            wb_data_q   <= bus.alu_result;
         end
         if (state == EXEC && !pass) skipped_cnt <= skipped_cnt + 1'b1;
         // an ALU flag update takes priority over the MSR write in the same cycle
         if (upd) flags <= {bus.alu_n, bus.alu_z, bus.alu_c, is_arith(op_q) ? bus.alu_v : flags[0]};
         else if (flags_we) flags <= flags_wdata;
      end
   end
endmodule

// File: tb/tb_arm_dp_sequencer.sv
// tb_arm_dp_sequencer: scoreboard bench with a behavioural ALU for arm_dp_sequencer
module tb_arm_dp_sequencer;
   import arm_dp_pkg::*;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flags_we = 1'b0;
   logic [3:0]  flags_wdata = 4'h0;
   logic [3:0]  flags;
   logic [15:0] retired_cnt, skipped_cnt;
   int          total = 0, bad = 0;
   int          mret = 0, mskip = 0;
   logic [3:0]  mf = 4'h0;
   logic [35:0] exp_q[$];
   logic [35:0] mon_e;
   arm_dp_sequencer_if #(.DATA_W(32)) bus ();
   arm_dp_sequencer #(.DATA_W(32), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave), .flags_we(flags_we),
      .flags_wdata(flags_wdata), .flags(flags), .retired_cnt(retired_cnt), .skipped_cnt(skipped_cnt)
   );
   always #5 clk = ~clk;
   // behavioural ALU: returns {N,Z,C,V,result}
   function automatic logic [35:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic cin);
      logic [32:0] s;
      logic [31:0] x, y, r;
      logic        ar, c, v;
      s = '0; x = a; y = b; ar = 1'b1; c = cin; v = 1'b0; r = '0;
      case (op)
         OP_SUB, OP_CMP: begin y = ~b; s = {1'b0, x} + {1'b0, y} + 33'd1; end
         OP_RSB:         begin x = b; y = ~a; s = {1'b0, x} + {1'b0, y} + 33'd1; end
         OP_ADD, OP_CMN: s = {1'b0, x} + {1'b0, y};
         OP_ADC:         s = {1'b0, x} + {1'b0, y} + {32'd0, cin};
         OP_SBC:         begin y = ~b; s = {1'b0, x} + {1'b0, y} + {32'd0, cin}; end
         OP_RSC:         begin x = b; y = ~a; s = {1'b0, x} + {1'b0, y} + {32'd0, cin}; end
         default:        ar = 1'b0;
      endcase
      if (ar) begin
         r = s[31:0];
         c = s[32];
         v = (x[31] == y[31]) && (r[31] != x[31]);
      end else begin
         case (op)
            OP_AND, OP_TST: r = a & b;
            OP_EOR, OP_TEQ: r = a ^ b;
            OP_ORR:         r = a | b;
            OP_MOV:         r = b;
            OP_BIC:         r = a & ~b;
            default:        r = ~b;
         endcase
      end
      return {r[31], r == 32'd0, c, v, r};
   endfunction
   function automatic logic cond_f(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cc, v, b;
      {n, z, cc, v} = f;
      case (c[3:1])
         3'd0:    b = z;
         3'd1:    b = cc;
         3'd2:    b = n;
         3'd3:    b = v;
         3'd4:    b = cc && !z;
         3'd5:    b = n == v;
         3'd6:    b = !z && (n == v);
         default: b = 1'b1;
      endcase
      return (c == 4'hF) ? 1'b0 : (c[0] ? !b : b);
   endfunction
   assign {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v, bus.alu_result} =
      alu_f(bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_carry);
   always @(negedge clk)
      if (!reset && bus.wb_valid && bus.wb_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL wb_unexpected got rd=%0d data=%h required=none", bus.wb_rd, bus.wb_data);
         end else begin
            mon_e = exp_q.pop_front();
            if ({bus.wb_rd, bus.wb_data} !== mon_e) begin
               bad++;
               $display("FAIL wb_data got rd=%0d data=%h required rd=%0d data=%h", bus.wb_rd, bus.wb_data, mon_e[35:32], mon_e[31:0]);
            end
         end
      end
   task automatic wait_idle();
      int n = 0;
      while (!bus.req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.req_ready) begin
         total++; bad++;
         $display("FAIL idle_timeout got req_ready=0 required 1");
      end
   endtask
   // drives one op through the handshake and advances the model; returns #1 after the accept edge
   task automatic issue(input logic [3:0] c, input logic [3:0] op, input logic s, input logic [3:0] rd,
                        input logic [31:0] a, input logic [31:0] b, input logic shc);
      logic [35:0] r;
      wait_idle();
      bus.req_cond = c; bus.req_opcode = op; bus.req_s = s; bus.req_rd = rd;
      bus.req_a = a; bus.req_b = b; bus.req_sh_carry = shc; bus.req_valid = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      r = alu_f(op, a, b, (op == OP_ADC || op == OP_SBC || op == OP_RSC) ? mf[1] : shc);
      if (cond_f(c, mf)) begin
         mret++;
         if (op[3:2] != 2'b10) exp_q.push_back({rd, r[31:0]});
         if (s || op[3:2] == 2'b10)
            mf = (op inside {[OP_SUB:OP_RSC], OP_CMP, OP_CMN}) ? r[35:32] : {r[35:33], mf[0]};
      end else mskip++;
   endtask
   task automatic msr(input logic [3:0] v);
      flags_we = 1'b1; flags_wdata = v;
      @(posedge clk); #1;
      flags_we = 1'b0;
      mf = v;
      total++;
      if (flags !== v) begin bad++; $display("FAIL msr_write got=%b required=%b", flags, v); end
   endtask
   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      mf = 4'h0; mret = 0; mskip = 0;
      total++;
      if ({bus.req_ready, bus.wb_valid} !== 2'b10) begin bad++; $display("FAIL reset_hs got=%b required=10", {bus.req_ready, bus.wb_valid}); end
      total++;
      if ({bus.wb_rd, bus.wb_data, flags} !== 40'd0) begin bad++; $display("FAIL reset_wb_flags got=%h required=0", {bus.wb_rd, bus.wb_data, flags}); end
      total++;
      if ({retired_cnt, skipped_cnt} !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%h required=0", {retired_cnt, skipped_cnt}); end
      total++;
      if ({bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_carry} !== 69'd0) begin bad++; $display("FAIL reset_alu got=%h required=0", {bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_carry}); end
   endtask
   task automatic test_add();
      issue(COND_AL, OP_ADD, 1'b1, 4'd1, 32'h7FFF_FFFF, 32'd1, 1'b0);
      @(posedge clk); #1;
      total++;
      if ({bus.wb_valid, bus.wb_data} !== {1'b1, 32'h8000_0000}) begin bad++; $display("FAIL add_latency got v=%b d=%h required v=1 d=80000000", bus.wb_valid, bus.wb_data); end
      @(posedge clk); #1;
      total++;
      if (flags !== 4'b1001) begin bad++; $display("FAIL add_flags got=%b required=1001", flags); end
      total++;
      if (retired_cnt !== 16'd1) begin bad++; $display("FAIL add_retired got=%0d required=1", retired_cnt); end
   endtask
   task automatic test_cmp();
      issue(COND_AL, OP_CMP, 1'b0, 4'd2, 32'd5, 32'd5, 1'b0);
      total++;
      if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL cmp_exec_ready got=%b required=0", bus.req_ready); end
      @(posedge clk); #1;
      total++;
      if ({bus.req_ready, bus.wb_valid} !== 2'b10) begin bad++; $display("FAIL cmp_done got=%b required=10", {bus.req_ready, bus.wb_valid}); end
      total++;
      if (flags !== 4'b0110) begin bad++; $display("FAIL cmp_flags got=%b required=0110", flags); end
   endtask
   task automatic test_skip();
      msr(4'b0000);
      issue(COND_EQ, OP_MOV, 1'b1, 4'd3, 32'd0, 32'h0000_DEAD, 1'b0);
      @(posedge clk); #1;
      total++;
      if ({bus.req_ready, bus.wb_valid} !== 2'b10) begin bad++; $display("FAIL skip_hs got=%b required=10", {bus.req_ready, bus.wb_valid}); end
      total++;
      if ({skipped_cnt, flags} !== {16'd1, 4'b0000}) begin bad++; $display("FAIL skip_state got skipped=%0d flags=%b required 1/0000", skipped_cnt, flags); end
   endtask
   task automatic test_adc();
      msr(4'b0010);
      issue(COND_AL, OP_ADC, 1'b0, 4'd4, 32'd1, 32'd1, 1'b0);
      total++;
      if ({bus.alu_carry, bus.alu_result} !== {1'b1, 32'd3}) begin bad++; $display("FAIL adc_carry got c=%b r=%h required c=1 r=3", bus.alu_carry, bus.alu_result); end
      @(posedge clk); #1;
      total++;
      if (bus.wb_data !== 32'd3) begin bad++; $display("FAIL adc_data got=%h required=3", bus.wb_data); end
      @(posedge clk); #1;
      total++;
      if (flags !== 4'b0010) begin bad++; $display("FAIL adc_flags got=%b required=0010", flags); end
   endtask
   task automatic test_backpressure();
      bus.wb_ready = 1'b0;
      issue(COND_AL, OP_MOV, 1'b0, 4'd7, 32'd0, 32'h1234_5678, 1'b0);
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({bus.wb_valid, bus.req_ready, bus.wb_rd, bus.wb_data} !== {2'b10, 4'd7, 32'h1234_5678}) begin
            bad++; $display("FAIL hold_wb cycle=%0d got v=%b rdy=%b d=%h required v=1 rdy=0 d=12345678", i, bus.wb_valid, bus.req_ready, bus.wb_data);
         end
         @(posedge clk); #1;
      end
      bus.wb_ready = 1'b1;
      issue(COND_AL, OP_EOR, 1'b0, 4'd8, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b0);
      total++;
      if (bus.alu_opcode !== OP_EOR) begin bad++; $display("FAIL next_accept got op=%h required=%h", bus.alu_opcode, OP_EOR); end
      wait_idle();
   endtask
   task automatic test_flags_conflict();
      issue(COND_AL, OP_CMP, 1'b0, 4'd5, 32'd3, 32'd5, 1'b0);
      flags_we = 1'b1; flags_wdata = 4'b1111;
      @(posedge clk); #1;
      flags_we = 1'b0;
      total++;
      if (flags !== 4'b1000) begin bad++; $display("FAIL conflict_flags got=%b required=1000", flags); end
   endtask
   task automatic test_random();
      logic [31:0] b;
      for (int i = 0; i < 60; i++) begin
         b = $urandom;
         issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom), 4'($urandom),
               ($urandom_range(0, 3) == 0) ? b : $urandom, b, 1'($urandom));
         wait_idle();
         total++;
         if (flags !== mf) begin bad++; $display("FAIL rand_flags op=%0d got=%b required=%b", i, flags, mf); end
      end
      total++;
      if ({retired_cnt, skipped_cnt} !== {16'(mret), 16'(mskip)}) begin
         bad++; $display("FAIL rand_cnt got r=%0d s=%0d required r=%0d s=%0d", retired_cnt, skipped_cnt, mret, mskip);
      end
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL sb_drain got=%0d required=0", exp_q.size()); end
   endtask
   task automatic test_reset_mid();
      bus.wb_ready = 1'b0;
      issue(COND_AL, OP_ADD, 1'b1, 4'd6, 32'hFFFF_FFFF, 32'd2, 1'b0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.delete();
      mf = 4'h0; mret = 0; mskip = 0;
      total++;
      if ({bus.wb_valid, bus.req_ready, flags} !== 6'b010000) begin bad++; $display("FAIL midreset got v=%b rdy=%b flags=%b required 0/1/0000", bus.wb_valid, bus.req_ready, flags); end
      total++;
      if ({retired_cnt, skipped_cnt} !== 32'd0) begin bad++; $display("FAIL midreset_cnt got=%h required=0", {retired_cnt, skipped_cnt}); end
      bus.wb_ready = 1'b1;
   endtask
   initial begin
      bus.req_valid = 1'b0; bus.req_cond = '0; bus.req_opcode = '0; bus.req_s = 1'b0;
      bus.req_rd = '0; bus.req_a = '0; bus.req_b = '0; bus.req_sh_carry = 1'b0; bus.wb_ready = 1'b1;
      test_reset();
      test_add();
      test_cmp();
      test_skip();
      test_adc();
      test_backpressure();
      test_flags_conflict();
      test_random();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
